// File: rtl/strength_window_pkg.sv
// Shared types for the 3x3 edge-strength window builder that feeds hysteresis.
package strength_window_pkg;
    typedef enum logic [1:0] {
        STR_NONE   = 2'b00,
        STR_WEAK   = 2'b01,
        STR_STRONG = 2'b10
    } str_class_t;

    typedef logic [17:0] str_window_t;

    localparam int CENTER_SLOT = 4;

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} win_state_t;

    // The reserved class code carries no edge information downstream.
    function automatic logic [1:0] sanitize_class(input logic [1:0] c);
        return (c == 2'b11) ? 2'(STR_NONE) : c;
    endfunction
endpackage

// File: rtl/strength_line_buf.sv
// History shift register of 2-bit classes exposing the nine 3x3 window taps.
module strength_line_buf #(
    parameter int W     = 640,
    parameter int DEPTH = 2*W + 3
) (
    input  logic            clk,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [1:0]      i_din,
    output logic [8:0][1:0] o_taps
);
    // The incoming class occupies offset 0 of the view, so the taps show the
    // history as it will look after this shift; the window register downstream
    // captures it on the same edge the shift happens.
    logic [DEPTH-2:0][1:0] r_sr;
    logic [DEPTH-1:0][1:0] w_view;

    assign w_view = {r_sr, i_din};

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr <= w_view[DEPTH-2:0];
        end
    end

    // Slot row*3+col: row 0 is the oldest line, col 0 the leftmost pixel.
    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign o_taps[gr*3+gc] = w_view[(2-gr)*W + 2 - gc];
        end
    end
endmodule

// File: rtl/strength_window.sv
// Streams one border-masked 3x3 class window per input pixel, centred on it.
module strength_window
    import strength_window_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_class,
    input  logic        in_valid,
    output logic        in_ready,
    output str_window_t strength,
    output logic        str_valid,
    output logic        frame_done
);
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(NPIX);
    localparam int FL_W  = $clog2(IMG_W + 1);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    win_state_t         r_state, w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [FL_W-1:0]    r_fcnt;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_ready, r_valid, r_done;
    str_window_t        r_strength;

    logic               w_acc, w_shift, w_emit, w_last_pos;
    logic [1:0]         w_din;
    logic [8:0][1:0]    w_taps, w_win;

    strength_line_buf #(.W(IMG_W), .DEPTH(2*IMG_W + 3)) u_hist (
        .clk    (clk),
        .i_clr  (rst),
        .i_en   (w_shift),
        .i_din  (w_din),
        .o_taps (w_taps)
    );

    always_comb begin
        w_next  = r_state;
        w_acc   = in_valid & r_ready;
        w_shift = 1'b0;
        w_emit  = 1'b0;
        w_din   = sanitize_class(in_class);
        case (r_state)
            FILL: begin
                if (w_acc) begin
                    w_shift = 1'b1;
                    if (r_idx == IDX_W'(IMG_W)) w_next = STREAM;
                end
            end
            STREAM: begin
                if (w_acc) begin
                    w_shift = 1'b1;
                    w_emit  = 1'b1;
                    if (r_idx == IDX_W'(NPIX - 1)) w_next = FLUSH;
                end
            end
            FLUSH: begin
                w_din   = 2'b00;
                w_shift = 1'b1;
                w_emit  = 1'b1;
                if (r_fcnt == FL_W'(IMG_W)) w_next = FILL;
            end
            default: w_next = FILL;
        endcase
    end

    // Stale history from a previous frame only ever lands in masked slots.
    always_comb begin
        w_win = w_taps;
        if (r_row == '0) begin
            w_win[0] = '0; w_win[1] = '0; w_win[2] = '0;
        end
        if (r_row == ROW_W'(IMG_H - 1)) begin
            w_win[6] = '0; w_win[7] = '0; w_win[8] = '0;
        end
        if (r_col == '0) begin
            w_win[0] = '0; w_win[3] = '0; w_win[6] = '0;
        end
        if (r_col == COL_W'(IMG_W - 1)) begin
            w_win[2] = '0; w_win[5] = '0; w_win[8] = '0;
        end
    end

    assign w_last_pos = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILL;
            r_idx      <= '0;
            r_fcnt     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_ready    <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_strength <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != FLUSH);
            r_valid <= w_emit;
            r_done  <= w_emit && w_last_pos;
            if (w_acc) begin
                r_idx <= (r_idx == IDX_W'(NPIX - 1)) ? '0 : r_idx + IDX_W'(1);
            end
            if (r_state == FLUSH) begin
                r_fcnt <= (r_fcnt == FL_W'(IMG_W)) ? '0 : r_fcnt + FL_W'(1);
            end
            if (w_emit) begin
                r_strength <= w_win;
                if (r_col == COL_W'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    assign in_ready   = r_ready;
    assign strength   = r_strength;
    assign str_valid  = r_valid;
    assign frame_done = r_done;
endmodule

// File: doc/strength_window.md
Name: strength_window

Overview:
- Builds 3x3 neighbourhoods of 2-bit edge-strength classes for the hysteresis stage, which consumes an 18-bit window plus valid.
- Sits directly upstream of hysteresis and downstream of the double-threshold classifier.
- Input is a raster-order stream of per-pixel classes. Output is one 18-bit window per input pixel, centred on that pixel, with out-of-image neighbours forced to "no edge".

Parameters:
- IMG_W, 640, image width in pixels (>= 2)
- IMG_H, 480, image height in pixels (>= 2)

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_class  input  2  pixel class: 00 none, 01 weak, 10 strong, 11 reserved
- in_valid  input  1  in_class valid this cycle
- in_ready  output  1  block accepts a pixel; transfer = in_valid & in_ready
- strength  output  18  window; slot i = strength[i*2+:2], i = row*3+col; row 0 = top (oldest line), col 0 = left; slot 4 = centre
- str_valid  output  1  strength valid for exactly this cycle; no backpressure
- frame_done  output  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Reset: in_ready=0 in the reset cycle, then 1. str_valid=0, frame_done=0, strength=0. All counters cleared, history storage cleared, state=FILL.
- Input sanitising: class 11 is stored as 00.
- Storage: history shift register of 2*IMG_W+3 classes (two full lines plus three).
  - The register shifts only on an accepted pixel or a flush step.
  - Taps at offsets {0,1,2, W,W+1,W+2, 2W,2W+1,2W+2} from newest form bottom, middle and top rows.
- Latency: the window for stream pixel k is emitted on the cycle after pixel k+IMG_W+1 is accepted. Outputs are registered.
- FSM:
  - FILL: in_ready=1. Accept the first IMG_W+1 pixels of a frame with no output, then go to STREAM.
  - STREAM: in_ready=1. Each accepted pixel produces one window next cycle. After the frame's last pixel (index W*H-1) is accepted, go to FLUSH.
  - FLUSH: in_ready=0. Shift in 00 once per cycle for IMG_W+1 cycles, emitting one window per cycle. Then return to FILL.
- Output count: exactly IMG_W*IMG_H windows per frame. frame_done accompanies window index W*H-1.
- Centre position counters (row r, col c) advance per emitted window. They wrap c at W-1 and r at H-1.
- Border masking, applied to outgoing slots:
  - r==0 zeroes slots 0-2; r==H-1 zeroes slots 6-8.
  - c==0 zeroes slots 0,3,6; c==W-1 zeroes slots 2,5,8.
  - Corner masks combine.
- Stall: in_valid low in FILL/STREAM means no shift, no output, and state is held. Gaps are unbounded.
- Back-to-back frames: the first pixel of frame n+1 is accepted the cycle after FLUSH ends. There is no inter-frame reuse of history: masking hides stale rows.
- Reset mid-frame: the partial frame is discarded and no further windows from it are emitted. The next accepted pixel is treated as pixel (0,0).
- Counter widths: $clog2(IMG_W*IMG_H) for the stream index; $clog2(IMG_W+1) for the flush count.

Decomposition:
- definitions_pkg gains:
  - enum str_class_t {STR_NONE=2'b00, STR_WEAK=2'b01, STR_STRONG=2'b10}
  - typedef logic [17:0] str_window_t
  - localparam CENTER_SLOT=4
  - FSM state enum win_state_t {FILL, STREAM, FLUSH}
- Sub-module strength_line_buf: parameterised-depth 2-bit shift register with enable and synchronous clear, exposing the nine taps. The border masking and FSM stay in strength_window.

Test Plan (IMG_W=4, IMG_H=3 unless stated):
- Reset then 12 back-to-back pixels, all 10 -> 12 windows. The centre window (r1,c1) is 0x2AAAA with no zeroed slots. Corner (0,0) = slots 4,5,7,8 strong only, i.e. 0x28A00. The first str_valid appears the cycle after pixel 5 is accepted. in_ready is low for exactly 5 FLUSH cycles. frame_done rises with the 12th window.
- Single strong pixel at (1,2), rest 00 -> exactly the windows centred on its 8 neighbours and itself carry 10 in the mirrored slot. For example, the window at (0,1) has slot 8=10 and the window at (1,2) has strength=0x00200. All others are 0.
- Class 11 injected at (1,1) -> every window containing it shows 00 in that slot.
- Random in_valid gaps (50%) with a fixed image -> window sequence identical to the gap-free run; no str_valid without a preceding acceptance or FLUSH step.
- rst asserted after 7 pixels, then a full new frame -> no stale windows. Output matches a clean single frame, including the top-row masking of the new frame.
- Two consecutive frames, IMG_W=2, IMG_H=2 -> 4 windows each, 3 flush cycles each, two frame_done pulses, with frame 2 unaffected by frame 1 data.
